// File: rtl/serial_add_ctrl.sv
// Serial wide adder: streams WIDTH-bit operands one nibble per clock through a
// single 4-bit ripple-carry stage, with valid/ready on the operand and result sides.
module serial_add_ctrl #(
  parameter int WIDTH = 16  // multiple of 4, minimum 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE and out_valid only in DONE, so the two sides
  // never overlap. Operands may change freely whenever in_ready is low; the
  // result is held stable while out_valid is high and out_ready is low.

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, co_q, ovf_q;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW+1:0]   bit_ofs;
  logic [3:0]        nib_a, nib_b, nib_sum;
  logic              nib_co;
  logic              last_nib;

  // Bit offset of the current nibble: idx * 4.
  assign bit_ofs  = {idx_q, 2'b00};
  assign last_nib = (idx_q == LAST_IDX);

  // 4-bit ripple-carry full-adder stage fed from the latched operands.
  always_comb begin
    logic c;
    nib_a   = a_q[bit_ofs +: 4];
    nib_b   = b_q[bit_ofs +: 4];
    nib_sum = 4'd0;
    c       = carry_q;
    for (int i = 0; i < 4; i++) begin
      nib_sum[i] = nib_a[i] ^ nib_b[i] ^ c;
      c          = (nib_a[i] & nib_b[i]) | (c & (nib_a[i] ^ nib_b[i]));
    end
    nib_co = c;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_RUN;
      S_RUN:   if (last_nib) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          // sum is intentionally left as-is on accept; it is only meaningful with out_valid.
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        S_RUN: begin
          sum_q[bit_ofs +: 4] <= nib_sum;
          carry_q             <= nib_co;
          idx_q               <= idx_q + 1'b1;
          if (last_nib) begin
            co_q  <= nib_co;
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign out_valid = (state == S_DONE);
  assign sum       = sum_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=16): table-driven vectors, multi-cycle
// corner sequences and a scoreboarded stream with random stalls.
module tb_serial_add_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;
  logic         busy;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W+1:0] exp_q[$];  // {co, ovf, sum}

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           hold;
    logic [W-1:0] exp_sum;
    logic         exp_co;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[10];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer addition, signed overflow from operand/result MSBs.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {full[W], v, full[W-1:0]};
  endfunction

  // One operation from IDLE: checks busy/out_valid timing, result, stall stability.
  task automatic do_op(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;  // accept edge E0
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("busy_in_run", {31'd0, busy}, 32'd1);
      check("no_out_valid_in_run", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("out_valid_after_n", {31'd0, out_valid}, 32'd1);
    check("busy_low_in_done", {31'd0, busy}, 32'd0);
    check("sum", {16'd0, sum}, {16'd0, v.exp_sum});
    check("co", {31'd0, co}, {31'd0, v.exp_co});
    check("ovf", {31'd0, ovf}, {31'd0, v.exp_ovf});
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("hold_sum", {16'd0, sum}, {16'd0, v.exp_sum});
      check("hold_flags", {30'd0, co, ovf}, {30'd0, v.exp_co, v.exp_ovf});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;  // output handshake edge
    out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_drops", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  // Streamed ops checked through the expected queue. In non-stall mode in_valid and
  // out_ready are held high and results must arrive at a fixed cadence.
  task automatic run_stream(input int nops, input bit stall);
    int  sent = 0, recv = 0, cyc = 0, last_cyc = -1;
    bit  pending = 1'b0;
    logic [W+1:0] e;
    while (recv < nops && cyc < 40 * nops + 100) begin
      @(posedge clk); #1;
      cyc++;
      if (!pending && sent < nops && (!stall || $urandom_range(0, 3) != 0)) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        pending = 1'b1;
      end
      in_valid  = pending;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin));
        sent++;
        pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_sum", {16'd0, sum}, {16'd0, e[W-1:0]});
          check("stream_co_ovf", {30'd0, co, ovf}, {30'd0, e[W+1], e[W]});
        end
        // One IDLE cycle to accept, N RUN cycles, one DONE cycle to hand off.
        if (!stall && last_cyc >= 0)
          check("stream_interval", 32'(cyc - last_cyc), 32'(N + 2));
        last_cyc = cyc;
        recv++;
      end
    end
    check("stream_all_results", 32'(recv), 32'(nops));
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    repeat (N + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'h1234, 16'h4321, 1'b1, 5, 16'h5556, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 0, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h5A5A, 16'h2525, 1'b0, 2, 16'h7F7F, 1'b0, 1'b0};
    vecs[8] = '{16'h4000, 16'h4000, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
    vecs[9] = '{16'h00F0, 16'h0010, 1'b0, 0, 16'h0100, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_sum", {16'd0, sum}, 32'd0);
    check("reset_co", {31'd0, co}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);

    for (int i = 0; i < 10; i++) do_op(vecs[i]);

    // Reset during the second RUN cycle aborts the operation.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
    @(posedge clk); #1;  // accept
    in_valid = 1'b0;
    @(posedge clk); #1;  // first nibble written
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {16'd0, sum}, 32'd0);
    repeat (N + 1) begin
      @(negedge clk);
      check("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    do_op('{16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0, 1'b0});

    run_stream(8, 1'b0);
    run_stream(300, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got no summary, expected finish");
    $fatal(1, "timeout");
  end

endmodule
